// File: rtl/counter_arbiter_pkg.sv
// counter_arbiter_pkg
// Shared types and default sizing for the counter arbiter slice.
// Optional feature macro used by the slice: COUNTER_ARBITER_RR_EN
// (round-robin arbitration instead of fixed lowest-index priority).
package counter_arbiter_pkg;

    // Ownership phases of the shared flexcounter
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_NREQ      = 4;
    localparam int DEFAULT_COUNTSIZE = 1024;

endpackage

// File: rtl/counter_arbiter_rr_picker.sv
// counter_arbiter_rr_picker
// The arbiter's rr_picker: scans the request vector starting at 'start',
// wrapping at NREQ, and returns the first requester found as a one-hot
// grant plus its index. With 'start' tied to zero this is plain
// fixed priority, lowest index first.
module counter_arbiter_rr_picker #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] start,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] idx,
    output logic            valid
);

    int pos;

    // Walk the requesters in circular order from 'start'; first hit wins
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        for (int i = 0; i < NREQ; i++) begin
            pos = int'(start) + i;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (!valid && req[pos]) begin
                valid    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IDXW'(pos);
            end
        end
    end

endmodule

// File: rtl/counter_arbiter.sv
// counter_arbiter
// Shares one flexcounter between NREQ one-shot delay requesters. A winner
// is picked in IDLE, its delay length is latched into cnt_max, the counter
// runs until its strobe, and a one-cycle done pulse goes back to the winner.
// Configuration macro: COUNTER_ARBITER_RR_EN selects round-robin arbitration
// (search starts one above the last winner); undefined gives fixed priority.
module counter_arbiter
    import counter_arbiter_pkg::*;
#(
    parameter int NREQ       = DEFAULT_NREQ,
    parameter int COUNTSIZE  = DEFAULT_COUNTSIZE,
    parameter int COUNTWIDTH = $clog2(COUNTSIZE)
) (
    input  logic                       clk,
    input  logic                       nRST,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*COUNTWIDTH-1:0] req_len,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            done,
    output logic                       busy,
    output logic                       cnt_enable,
    output logic [COUNTWIDTH-1:0]      cnt_max,
    input  logic                       cnt_strobe,
    input  logic [COUNTWIDTH-1:0]      cnt_count
);

    localparam int IDXW = $clog2(NREQ);

    state_t                state, state_next;
    logic [NREQ-1:0]       gnt_q, gnt_next;
    logic [COUNTWIDTH-1:0] max_q, max_next;
    logic [COUNTWIDTH-1:0] sel_len;
    logic [NREQ-1:0]       pick_gnt;
    logic [IDXW-1:0]       pick_idx;
    logic                  pick_valid;
    logic [IDXW-1:0]       start;
    logic                  owner_req;
    logic                  expired;

    counter_arbiter_rr_picker #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_picker (
        .req   (req),
        .start (start),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef COUNTER_ARBITER_RR_EN
    logic [IDXW-1:0] ptr_q;

    // Round-robin pointer: moves to one above each new winner, only on grant
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ptr_q <= '0;
        end else if (state == IDLE && pick_valid) begin
            if (pick_idx == IDXW'(NREQ - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= pick_idx + IDXW'(1);
            end
        end
    end

    assign start = ptr_q;
`else
    assign start = '0;
`endif

    // Select the candidate winner's delay length out of the packed bus
    always_comb begin
        sel_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDXW'(i)) begin
                sel_len = req_len[i*COUNTWIDTH +: COUNTWIDTH];
            end
        end
    end

    assign owner_req = |(req & gnt_q);
    assign expired   = cnt_strobe || (cnt_count > max_q);

    // State, owner and terminal-count registers
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            gnt_q <= '0;
            max_q <= '0;
        end else begin
            state <= state_next;
            gnt_q <= gnt_next;
            max_q <= max_next;
        end
    end

    // Next-state logic; a withdrawn request beats a coincident strobe
    always_comb begin
        state_next = state;
        gnt_next   = gnt_q;
        max_next   = max_q;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    gnt_next   = pick_gnt;
                    max_next   = sel_len;
                    state_next = (sel_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (!owner_req) begin
                    state_next = IDLE;
                    gnt_next   = '0;
                end else if (expired) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    assign gnt        = gnt_q;
    assign done       = (state == DONE) ? gnt_q : '0;
    assign busy       = (state != IDLE);
    assign cnt_enable = (state == RUN);
    assign cnt_max    = max_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter
// Self-checking bench for counter_arbiter with a behavioural flexcounter.
// Honours COUNTER_ARBITER_RR_EN for the expected grant order.
module tb_counter_arbiter;

    localparam int NREQ = 4;
    localparam int COUNTSIZE = 1024;
    localparam int CW = $clog2(COUNTSIZE);

    logic clk = 1'b0;
    logic nRST;
    logic [NREQ-1:0] req;
    logic [NREQ*CW-1:0] req_len;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic busy;
    logic cnt_enable;
    logic [CW-1:0] cnt_max;
    logic cnt_strobe;
    logic [CW-1:0] cnt_count;
    logic strobe_kill;

    int checks = 0;
    int failures = 0;

    // reference model state
    int m_owner;
    int m_len;
    int m_k;
    int m_ptr;

    counter_arbiter #(
        .NREQ       (NREQ),
        .COUNTSIZE  (COUNTSIZE),
        .COUNTWIDTH (CW)
    ) dut (
        .clk        (clk),
        .nRST       (nRST),
        .req        (req),
        .req_len    (req_len),
        .gnt        (gnt),
        .done       (done),
        .busy       (busy),
        .cnt_enable (cnt_enable),
        .cnt_max    (cnt_max),
        .cnt_strobe (cnt_strobe),
        .cnt_count  (cnt_count)
    );

    always #5 clk = ~clk;

    // Behavioural flexcounter: clears while disabled, counts while enabled
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cnt_count <= '0;
        end else if (!cnt_enable) begin
            cnt_count <= '0;
        end else begin
            cnt_count <= cnt_count + 1'b1;
        end
    end

    assign cnt_strobe = cnt_enable && (cnt_count == cnt_max) && !strobe_kill;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        req = '0;
        req_len = '0;
        strobe_kill = 1'b0;
        repeat (2) @(negedge clk);
        nRST = 1'b1;
    endtask

    task automatic set_len(input int i, input int v);
        req_len[i*CW +: CW] = CW'(v);
    endtask

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i] && r < 0) r = i;
        end
        return r;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (gnt !== '0) begin failures++; $display("[TB] FAIL reset_gnt: got %b expected 0", gnt); end
        checks++; if (done !== '0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (cnt_enable !== 1'b0) begin failures++; $display("[TB] FAIL reset_enable: got %b expected 0", cnt_enable); end
        checks++; if (cnt_max !== '0) begin failures++; $display("[TB] FAIL reset_max: got %0d expected 0", cnt_max); end
        nRST = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || gnt !== '0) begin failures++; $display("[TB] FAIL reset_idle: busy %b gnt %b expected 0 0", busy, gnt); end
    endtask

    task automatic test_single();
        int k;
        int strobe_k;
        strobe_k = -1;
        set_len(2, 5);
        req = 4'b0100;
        tick();
        checks++; if (gnt !== 4'b0100) begin failures++; $display("[TB] FAIL single_gnt: got %b expected 0100", gnt); end
        checks++; if (cnt_max !== CW'(5)) begin failures++; $display("[TB] FAIL single_max: got %0d expected 5", cnt_max); end
        checks++; if (cnt_enable !== 1'b1 || busy !== 1'b1) begin failures++; $display("[TB] FAIL single_run: enable %b busy %b expected 1 1", cnt_enable, busy); end
        for (k = 1; k <= 20; k++) begin
            tick();
            if (cnt_strobe && strobe_k < 0) strobe_k = k;
            if (done !== '0) break;
        end
        checks++; if (k != 6) begin failures++; $display("[TB] FAIL single_latency: got %0d expected 6", k); end
        checks++; if (strobe_k != 5) begin failures++; $display("[TB] FAIL single_strobe: got cycle %0d expected 5", strobe_k); end
        checks++; if (done !== 4'b0100) begin failures++; $display("[TB] FAIL single_done: got %b expected 0100", done); end
        req = '0;
        tick();
        checks++; if (done !== '0 || gnt !== '0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL single_after: done %b gnt %b busy %b expected 0 0 0", done, gnt, busy); end
    endtask

    task automatic test_zero_len();
        logic en_seen;
        set_len(0, 0);
        req = 4'b0001;
        tick();
        en_seen = cnt_enable;
        checks++; if (gnt !== 4'b0001) begin failures++; $display("[TB] FAIL zero_gnt: got %b expected 0001", gnt); end
        checks++; if (done !== 4'b0001) begin failures++; $display("[TB] FAIL zero_done: got %b expected 0001", done); end
        req = '0;
        tick();
        en_seen = en_seen | cnt_enable;
        checks++; if (done !== '0 || gnt !== '0) begin failures++; $display("[TB] FAIL zero_after: done %b gnt %b expected 0 0", done, gnt); end
        checks++; if (en_seen !== 1'b0) begin failures++; $display("[TB] FAIL zero_enable: got %b expected 0", en_seen); end
    endtask

    task automatic test_fairness();
        int order[$];
        int last_done_t;
        logic [NREQ-1:0] prev_gnt;
        int exp;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_len(i, 3);
        req = '1;
        prev_gnt = '0;
        last_done_t = 0;
        for (int t = 0; t < 200 && order.size() < 5; t++) begin
            tick();
            if (gnt !== '0 && prev_gnt === '0) begin
                order.push_back(oh_idx(gnt));
                if (order.size() > 1) begin
                    checks++; if (t - last_done_t != 2) begin failures++; $display("[TB] FAIL fair_gap: got %0d expected 2", t - last_done_t); end
                end
            end
            if (done !== '0) begin
                last_done_t = t;
                req = req & ~done;
            end else begin
                req = '1;
            end
            prev_gnt = gnt;
        end
        checks++; if (order.size() != 5) begin failures++; $display("[TB] FAIL fair_count: got %0d expected 5", order.size()); end
        for (int i = 0; i < order.size(); i++) begin
`ifdef COUNTER_ARBITER_RR_EN
            exp = i % NREQ;
`else
            exp = 0;
`endif
            checks++; if (order[i] != exp) begin failures++; $display("[TB] FAIL fair_order%0d: got %0d expected %0d", i, order[i], exp); end
        end
        do_reset();
    endtask

    task automatic test_abort();
        logic done_seen;
        int k;
        done_seen = 1'b0;
        set_len(3, 100);
        req = 4'b1000;
        tick();
        for (k = 0; k < 150 && cnt_count !== CW'(40); k++) begin
            tick();
            done_seen = done_seen | (|done);
        end
        checks++; if (cnt_count !== CW'(40)) begin failures++; $display("[TB] FAIL abort_reach: got %0d expected 40", cnt_count); end
        req = '0;
        tick();
        checks++; if (cnt_enable !== 1'b0 || busy !== 1'b0 || gnt !== '0) begin failures++; $display("[TB] FAIL abort_drop: enable %b busy %b gnt %b expected 0 0 0", cnt_enable, busy, gnt); end
        checks++; if (done_seen !== 1'b0 || done !== '0) begin failures++; $display("[TB] FAIL abort_done: got %b expected no done", done); end
        set_len(1, 4);
        req = 4'b0010;
        tick();
        checks++; if (gnt !== 4'b0010) begin failures++; $display("[TB] FAIL abort_next_gnt: got %b expected 0010", gnt); end
        checks++; if (cnt_count !== '0) begin failures++; $display("[TB] FAIL abort_next_count: got %0d expected 0", cnt_count); end
        for (k = 0; k < 20 && done === '0; k++) tick();
        req = '0;
        tick();
    endtask

    task automatic test_len_change();
        int k;
        set_len(1, 10);
        req = 4'b0010;
        tick();
        set_len(1, 2);
        for (k = 1; k <= 30; k++) begin
            tick();
            if (done !== '0) break;
        end
        checks++; if (k != 11) begin failures++; $display("[TB] FAIL lenchg_latency: got %0d expected 11", k); end
        checks++; if (cnt_max !== CW'(10)) begin failures++; $display("[TB] FAIL lenchg_max: got %0d expected 10", cnt_max); end
        checks++; if (done !== 4'b0010) begin failures++; $display("[TB] FAIL lenchg_done: got %b expected 0010", done); end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid_run();
        set_len(1, 50);
        req = 4'b0010;
        tick();
        for (int k = 0; k < 60 && cnt_count !== CW'(20); k++) tick();
        checks++; if (cnt_count !== CW'(20) || busy !== 1'b1) begin failures++; $display("[TB] FAIL rstrun_reach: count %0d busy %b expected 20 1", cnt_count, busy); end
        #2;
        nRST = 1'b0;
        #1;
        checks++; if (gnt !== '0 || done !== '0) begin failures++; $display("[TB] FAIL rstrun_gnt: gnt %b done %b expected 0 0", gnt, done); end
        checks++; if (busy !== 1'b0 || cnt_enable !== 1'b0) begin failures++; $display("[TB] FAIL rstrun_busy: busy %b enable %b expected 0 0", busy, cnt_enable); end
        checks++; if (cnt_max !== '0) begin failures++; $display("[TB] FAIL rstrun_max: got %0d expected 0", cnt_max); end
        @(negedge clk);
        req = '0;
        nRST = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || cnt_enable !== 1'b0) begin failures++; $display("[TB] FAIL rstrun_after: busy %b enable %b expected 0 0", busy, cnt_enable); end
    endtask

    task automatic test_overrun();
        int k;
        strobe_kill = 1'b1;
        set_len(0, 3);
        req = 4'b0001;
        tick();
        for (k = 1; k <= 20; k++) begin
            tick();
            if (done !== '0) break;
        end
        checks++; if (k != 5) begin failures++; $display("[TB] FAIL overrun_latency: got %0d expected 5", k); end
        strobe_kill = 1'b0;
        req = '0;
        tick();
    endtask

    // Advance the transaction-level model by one clock edge
    task automatic model_step();
        int w;
        logic fin;
        if (m_owner < 0) begin
            if (req != '0) begin
                w = -1;
`ifdef COUNTER_ARBITER_RR_EN
                for (int n = 0; n < NREQ; n++) begin
                    if (w < 0 && req[(m_ptr + n) % NREQ]) w = (m_ptr + n) % NREQ;
                end
                m_ptr = (w + 1) % NREQ;
`else
                w = oh_idx(req);
`endif
                m_owner = w;
                m_len = int'(req_len[w*CW +: CW]);
                m_k = 0;
            end
        end else begin
            fin = (m_len == 0) ? (m_k == 0) : (m_k == m_len + 1);
            if (fin) m_owner = -1;
            else if (!req[m_owner]) m_owner = -1;
            else m_k++;
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] e_gnt;
        logic [NREQ-1:0] e_done;
        logic e_fin;
        logic e_en;
        do_reset();
        m_owner = -1;
        m_len = 0;
        m_k = 0;
        m_ptr = 0;
        for (int c = 0; c < 800; c++) begin
            e_gnt = '0;
            e_fin = 1'b0;
            if (m_owner >= 0) begin
                e_gnt[m_owner] = 1'b1;
                e_fin = (m_len == 0) ? (m_k == 0) : (m_k == m_len + 1);
            end
            e_done = e_fin ? e_gnt : '0;
            e_en = (m_owner >= 0) && !e_fin;
            checks++; if (gnt !== e_gnt) begin failures++; $display("[TB] FAIL rand_gnt c%0d: got %b expected %b", c, gnt, e_gnt); end
            checks++; if (done !== e_done) begin failures++; $display("[TB] FAIL rand_done c%0d: got %b expected %b", c, done, e_done); end
            checks++; if (busy !== (m_owner >= 0)) begin failures++; $display("[TB] FAIL rand_busy c%0d: got %b expected %b", c, busy, m_owner >= 0); end
            checks++; if (cnt_enable !== e_en) begin failures++; $display("[TB] FAIL rand_enable c%0d: got %b expected %b", c, cnt_enable, e_en); end
            if (m_owner >= 0) begin
                checks++; if (cnt_max !== CW'(m_len)) begin failures++; $display("[TB] FAIL rand_max c%0d: got %0d expected %0d", c, cnt_max, m_len); end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (i == m_owner && e_fin) begin
                    req[i] = 1'b0;
                end else if (i == m_owner) begin
                    if ($urandom_range(39, 0) == 0) req[i] = 1'b0;
                    if ($urandom_range(7, 0) == 0) set_len(i, int'($urandom_range(12, 0)));
                end else if (req[i]) begin
                    if ($urandom_range(29, 0) == 0) req[i] = 1'b0;
                end else if ($urandom_range(3, 0) == 0) begin
                    req[i] = 1'b1;
                    set_len(i, int'($urandom_range(12, 0)));
                end
            end
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
        req = '0;
    endtask

    // Hard stop so a stuck run still ends with a visible failure
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        nRST = 1'b0;
        req = '0;
        req_len = '0;
        strobe_kill = 1'b0;
        test_reset();
        test_single();
        test_zero_len();
        test_fairness();
        test_abort();
        test_len_change();
        test_reset_mid_run();
        test_overrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
